// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmit arbiter slice.
//   - UART_DATA_W     : serialiser byte width
//   - FRAME_TICKS_DEF : default baud ticks per frame (1 start + 8 data + 2 stop)
//   - GAP_CYCLES_DEF  : default idle clocks after a frame
//   - arb_state_e     : arbiter FSM states ARB_IDLE..ARB_GAP
//   - wrap_inc()      : modulo-n increment used for the round-robin pointer
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned UART_DATA_W     = 8;
    localparam int unsigned FRAME_TICKS_DEF = 11;
    localparam int unsigned GAP_CYCLES_DEF  = 2;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_LOAD  = 3'd1,
        ARB_START = 3'd2,
        ARB_WAIT  = 3'd3,
        ARB_GAP   = 3'd4
    } arb_state_e;

    // Increment v, wrapping n-1 back to 0.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// ----------------------------------------------------------------------------
// uart_rr_pick
//   Combinational round-robin picker. Scans the request vector starting at the
//   pointer position and wrapping N_REQ-1 -> 0; the first set bit wins.
//   Ports:
//     i_req   [N_REQ]  request vector
//     i_ptr   [IDX_W]  scan start index (must be < N_REQ)
//     o_grant [N_REQ]  one-hot grant (all zero when no request)
//     o_idx   [IDX_W]  index of the granted request
//     o_any   1        at least one request present
// ----------------------------------------------------------------------------
module uart_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        int unsigned cand;
        logic        found;
        cand    = 0;
        found   = 1'b0;
        o_grant = '0;
        o_idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = (32'(i_ptr) + i) % N_REQ;
            if (!found && i_req[IDX_W'(cand)]) begin
                found                   = 1'b1;
                o_grant[IDX_W'(cand)]   = 1'b1;
                o_idx                   = IDX_W'(cand);
            end
        end
        o_any = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one uart_tx serialiser between N_REQ byte requesters. A winner is
//   picked round-robin while idle, its byte is latched and held on o_tx_data,
//   o_tx_en pulses once, and the frame is timed by counting i_bd ticks before
//   a short gap and the next grant.
//   Build option: define UART_ARB_PRIO0_EN to give requester 0 strict priority
//   (others round-robin among themselves; a grant to 0 leaves the pointer).
//   Ports:
//     i_clk        clock
//     i_rst_n      asynchronous active-low reset (drops any frame in flight)
//     i_bd         1-cycle baud tick shared with the serialiser
//     i_req_valid  per-requester byte valid
//     i_req_data   byte of requester k at [8k+7:8k]
//     o_req_ready  one-hot accept strobe, only while idle
//     o_tx_en      1-cycle start pulse to the serialiser
//     o_tx_data    byte to the serialiser, stable from LOAD to end of GAP
//     o_busy       high in every state except idle
//     o_grant_id   index of the last granted requester
//   GAP_CYCLES must be at least 1.
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned FRAME_TICKS = FRAME_TICKS_DEF,
    parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_bd,
    input  logic [N_REQ-1:0]             i_req_valid,
    input  logic [UART_DATA_W*N_REQ-1:0] i_req_data,
    output logic [N_REQ-1:0]             o_req_ready,
    output logic                         o_tx_en,
    output logic [UART_DATA_W-1:0]       o_tx_data,
    output logic                         o_busy,
    output logic [$clog2(N_REQ)-1:0]     o_grant_id
);

    localparam int unsigned IDX_W  = $clog2(N_REQ);
    localparam int unsigned TICK_W = $clog2(FRAME_TICKS + 1);
    localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);

    arb_state_e state_q, state_d;

    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       gid_q, gid_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic [TICK_W-1:0]      tick_q, tick_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic                   tx_en_q;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic [N_REQ-1:0]       rr_req;
    logic [N_REQ-1:0]       rr_grant;
    logic [IDX_W-1:0]       rr_idx;
    logic                   rr_any;

    logic [N_REQ-1:0]       win_grant;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_any;
    logic                   win_moves_ptr;
    logic [UART_DATA_W-1:0] win_byte;
    logic                   accept;

`ifdef UART_ARB_PRIO0_EN
    // Requester 0 is handled outside the round-robin ring.
    assign rr_req = {i_req_valid[N_REQ-1:1], 1'b0};
`else
    assign rr_req = i_req_valid;
`endif

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req   (rr_req),
        .i_ptr   (ptr_q),
        .o_grant (rr_grant),
        .o_idx   (rr_idx),
        .o_any   (rr_any)
    );

    always_comb begin
        win_grant     = rr_grant;
        win_idx       = rr_idx;
        win_any       = rr_any;
        win_moves_ptr = 1'b1;
`ifdef UART_ARB_PRIO0_EN
        if (i_req_valid[0]) begin
            win_grant     = N_REQ'(1);
            win_idx       = '0;
            win_any       = 1'b1;
            win_moves_ptr = 1'b0;
        end
`endif
    end

    // Unpack the byte lanes so the winner can be selected by index.
    logic [UART_DATA_W-1:0] req_bytes [N_REQ];
    for (genvar k = 0; k < N_REQ; k++) begin : g_lane
        assign req_bytes[k] = i_req_data[k*UART_DATA_W +: UART_DATA_W];
    end

    assign win_byte = req_bytes[win_idx];
    assign accept   = (state_q == ARB_IDLE) && win_any;

    // ------------------------------------------------------------------------
    // Frame timing
    // ------------------------------------------------------------------------
    logic frame_done;
    logic gap_done;

    // Only ticks seen while in WAIT count; a tick during START is ignored.
    assign frame_done = (state_q == ARB_WAIT) && i_bd &&
                        (tick_q == TICK_W'(FRAME_TICKS - 1));
    assign gap_done   = (state_q == ARB_GAP) && (gap_q == GAP_W'(GAP_CYCLES - 1));

    always_comb begin
        tick_d = tick_q;
        if (state_q == ARB_WAIT && i_bd) begin
            if (frame_done) begin
                tick_d = '0;
            end else if (tick_q != TICK_W'(FRAME_TICKS)) begin
                tick_d = tick_q + 1'b1;
            end
        end
    end

    always_comb begin
        gap_d = '0;
        if (state_q == ARB_GAP && !gap_done) begin
            gap_d = gap_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Grant bookkeeping and byte latch
    // ------------------------------------------------------------------------
    always_comb begin
        ptr_d  = ptr_q;
        gid_d  = gid_q;
        data_d = data_q;
        if (accept) begin
            data_d = win_byte;
            gid_d  = win_idx;
            if (win_moves_ptr) begin
                ptr_d = IDX_W'(wrap_inc(32'(win_idx), N_REQ));
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE:  if (win_any) state_d = ARB_LOAD;
            ARB_LOAD:  state_d = ARB_START;
            ARB_START: state_d = ARB_WAIT;
            ARB_WAIT:  if (frame_done) state_d = ARB_GAP;
            ARB_GAP:   if (gap_done) state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_busy      = (state_q != ARB_IDLE);
        o_req_ready = '0;
        // Gate with reset so no strobe is offered while the arbiter is held.
        if (state_q == ARB_IDLE && i_rst_n) begin
            o_req_ready = win_grant;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q   <= '0;
            gid_q   <= '0;
            data_q  <= '0;
            tick_q  <= '0;
            gap_q   <= '0;
            tx_en_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            data_q  <= data_d;
            tick_q  <= tick_d;
            gap_q   <= gap_d;
            // Registered so the pulse is high exactly for the START cycle.
            tx_en_q <= (state_d == ARB_START);
        end
    end

    assign o_tx_en    = tx_en_q;
    assign o_tx_data  = data_q;
    assign o_grant_id = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int FT  = 11;
    localparam int GAP = 2;

    localparam int MODE_HOLD    = 0;
    localparam int MODE_ONESHOT = 1;
    localparam int MODE_RANDOM  = 2;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_bd;
    logic [3:0]  i_req_valid;
    logic [31:0] i_req_data;
    logic [3:0]  o_req_ready;
    logic        o_tx_en;
    logic [7:0]  o_tx_data;
    logic        o_busy;
    logic [1:0]  o_grant_id;

    always #5 i_clk = ~i_clk;

    uart_tx_arbiter #(
        .N_REQ       (N),
        .FRAME_TICKS (FT),
        .GAP_CYCLES  (GAP)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_bd        (i_bd),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .o_req_ready (o_req_ready),
        .o_tx_en     (o_tx_en),
        .o_tx_data   (o_tx_data),
        .o_busy      (o_busy),
        .o_grant_id  (o_grant_id)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    // Requester-side stimulus state
    logic [3:0] rq_valid;
    logic [7:0] rq_byte [4];
    int         mode;
    bit         bd_random;

    // Reference model: a frame is described by its grant cycle and the cycle
    // at which the arbiter is free again (known once the 11th tick is seen).
    bit         m_active;
    int         m_g, m_ticks, m_end, m_ptr, m_gid;
    logic [7:0] m_data;
    logic [3:0] m_acc;

    // Observation counters
    int  obs_q [$];
    int  n_txen, n_rdy3, n_busy, last_rdy_cyc, t_txen;
    bit  prev_txen;

    typedef struct {
        logic [3:0] mask;
        int         n;
        int         exp [5];
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int ptr);
        int r;
        r = -1;
`ifdef UART_ARB_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int i = 0; i < N; i++) begin
            int k;
            k = (ptr + i) % N;
            if (r < 0 && v[k]) r = k;
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [3:0] mask, input int n,
                                input int e0, input int e1, input int e2,
                                input int e3, input int e4);
        vec_t v;
        v.mask   = mask;
        v.n      = n;
        v.exp[0] = e0;
        v.exp[1] = e1;
        v.exp[2] = e2;
        v.exp[3] = e3;
        v.exp[4] = e4;
        return v;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_ptr    = 0;
        m_gid    = 0;
        m_data   = 8'h00;
        m_acc    = 4'b0;
        m_end    = -1;
        prev_txen = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"},    32'(o_req_ready), 0);
        chk({tag, "_tx_en"},    32'(o_tx_en),     0);
        chk({tag, "_tx_data"},  32'(o_tx_data),   0);
        chk({tag, "_busy"},     32'(o_busy),      0);
        chk({tag, "_grant_id"}, 32'(o_grant_id),  0);
    endtask

    task automatic drive_ports();
        i_req_valid = rq_valid;
        for (int k = 0; k < N; k++) i_req_data[k*8 +: 8] = rq_byte[k];
    endtask

    // One clock: requesters react to last cycle's accept, inputs are driven at
    // the falling edge, outputs compared 1 time unit later, model advanced for
    // the following rising edge.
    task automatic cycle_step();
        int         w;
        bit         idle;
        logic [3:0] er;
        @(negedge i_clk);
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (mode == MODE_ONESHOT && m_acc[k]) begin
                rq_valid[k] = 1'b0;
            end else if (mode == MODE_RANDOM) begin
                if (m_acc[k] || !rq_valid[k]) begin
                    rq_valid[k] = ($urandom_range(0, 3) == 0);
                    rq_byte[k]  = 8'($urandom);
                end else if ($urandom_range(0, 63) == 0) begin
                    rq_valid[k] = 1'b0;
                end
            end
        end
        drive_ports();
        i_bd = bd_random ? ($urandom_range(0, 15) == 0) : (cyc % 16 == 0);
        #1;
        if (m_active && m_end >= 0 && cyc >= m_end) m_active = 1'b0;
        idle = !m_active;
        w    = idle ? pick(rq_valid, m_ptr) : -1;
        er   = (w >= 0) ? (4'b0001 << w) : 4'b0000;
        chk("ready",    32'(o_req_ready), 32'(er));
        chk("busy",     32'(o_busy),      32'(!idle));
        chk("tx_en",    32'(o_tx_en),     32'(m_active && cyc == m_g + 2));
        chk("tx_data",  32'(o_tx_data),   32'(m_data));
        chk("grant_id", 32'(o_grant_id),  32'(m_gid));
        m_acc = er;
        if (o_req_ready != 4'b0) begin
            last_rdy_cyc = cyc;
            for (int k = 0; k < N; k++) if (o_req_ready[k]) obs_q.push_back(k);
        end
        if (o_req_ready[3]) n_rdy3++;
        if (o_busy) n_busy++;
        if (o_tx_en) begin
            n_txen++;
            t_txen = cyc;
            chk("accept_to_txen", 32'(cyc - last_rdy_cyc), 2);
            chk("txen_width", 32'(prev_txen), 0);
        end
        prev_txen = o_tx_en;
        if (w >= 0) begin
            m_active = 1'b1;
            m_g      = cyc;
            m_ticks  = 0;
            m_end    = -1;
            m_data   = rq_byte[w];
            m_gid    = w;
`ifdef UART_ARB_PRIO0_EN
            if (w != 0) m_ptr = (w + 1) % N;
`else
            m_ptr = (w + 1) % N;
`endif
        end else if (m_active && m_end < 0 && cyc >= m_g + 3 && i_bd) begin
            m_ticks++;
            if (m_ticks == FT) m_end = cyc + 1 + GAP;
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n  = 1'b0;
        rq_valid = 4'b0;
        drive_ports();
        i_bd     = 1'b0;
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic run_until(input int grants, input int budget, input string tag);
        for (int c = 0; c < budget && obs_q.size() < grants; c++) cycle_step();
        if (obs_q.size() < grants) chk({tag, "_timeout"}, 32'(obs_q.size()), 32'(grants));
    endtask

    initial begin
        tbl[0] = mk(4'b0010, 3, 1, 1, 1, 0, 0);
        tbl[3] = mk(4'b1100, 3, 2, 3, 2, 0, 0);
        tbl[5] = mk(4'b1110, 4, 1, 2, 3, 1, 0);
`ifdef UART_ARB_PRIO0_EN
        tbl[1] = mk(4'b1111, 5, 0, 0, 0, 0, 0);
        tbl[2] = mk(4'b0101, 4, 0, 0, 0, 0, 0);
        tbl[4] = mk(4'b1001, 3, 0, 0, 0, 0, 0);
`else
        tbl[1] = mk(4'b1111, 5, 0, 1, 2, 3, 0);
        tbl[2] = mk(4'b0101, 4, 0, 2, 0, 2, 0);
        tbl[4] = mk(4'b1001, 3, 0, 3, 0, 0, 0);
`endif
        mode      = MODE_HOLD;
        bd_random = 1'b0;
        n_txen = 0; n_rdy3 = 0; n_busy = 0; last_rdy_cyc = 0; t_txen = 0;
        for (int k = 0; k < N; k++) rq_byte[k] = 8'h00;
        i_rst_n    = 1'b0;
        rq_valid   = 4'b0;
        i_req_data = '0;
        drive_ports();
        i_bd = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(negedge i_clk);
        #1 chk_all_zero("reset");
        do_reset();

        // Table: persistent request masks and the expected grant order
        for (int i = 0; i < 6; i++) begin
            do_reset();
            mode = MODE_HOLD;
            for (int k = 0; k < N; k++) rq_byte[k] = 8'h10 + 8'(k);
            rq_valid = tbl[i].mask;
            obs_q.delete();
            run_until(tbl[i].n, 200 * tbl[i].n, $sformatf("table%0d", i));
            for (int j = 0; j < tbl[i].n; j++) begin
                if (j < obs_q.size())
                    chk($sformatf("table%0d_grant%0d", i, j), 32'(obs_q[j]), 32'(tbl[i].exp[j]));
            end
        end

        // Five frames from all-valid: exactly five start pulses
        do_reset();
        mode = MODE_HOLD;
        rq_valid = 4'b1111;
        obs_q.delete();
        n_txen = 0;
        run_until(6, 1200, "five_frames");
        chk("txen_count_5frames", 32'(n_txen), 5);

        // Req1 sends A5 alone
        do_reset();
        mode = MODE_ONESHOT;
        rq_byte[1] = 8'hA5;
        rq_valid   = 4'b0010;
        obs_q.delete();
        n_busy = 0; n_txen = 0;
        repeat (260) cycle_step();
        chk("a5_grants", 32'(obs_q.size()), 1);
        chk("a5_txen_count", 32'(n_txen), 1);
        chk("a5_grant_id", 32'(o_grant_id), 1);
        chk("a5_data_held", 32'(o_tx_data), 32'h A5);
        begin
            int first_bd, c11;
            first_bd = ((t_txen + 1 + 15) / 16) * 16;
            c11      = first_bd + 16 * (FT - 1);
            chk("a5_busy_cycles", 32'(n_busy), 32'(c11 - t_txen + 4));
        end

        // Reset mid-WAIT, then req2/req3 compete with pointer back at 0
        do_reset();
        mode = MODE_ONESHOT;
        rq_byte[2] = 8'h22;
        rq_byte[3] = 8'h33;
        rq_valid   = 4'b0100;
        obs_q.delete();
        for (int c = 0; c < 200 && !(m_active && cyc == m_g + 40); c++) cycle_step();
        chk("mid_wait_reached", 32'(m_active && cyc == m_g + 40), 1);
        #2;
        i_rst_n     = 1'b0;
        i_req_valid = 4'b1100;
        #1 chk_all_zero("async_reset");
        model_reset();
        i_req_valid = 4'b0;
        @(negedge i_clk);
        i_rst_n  = 1'b1;
        mode     = MODE_HOLD;
        rq_valid = 4'b1100;
        obs_q.delete();
        run_until(1, 20, "post_reset");
        if (obs_q.size() > 0) chk("post_reset_first_grant", 32'(obs_q[0]), 2);

        // Req3 raises then drops valid while another frame is in flight
        do_reset();
        mode       = MODE_ONESHOT;
        rq_byte[0] = 8'h5A;
        rq_valid   = 4'b0001;
        n_rdy3 = 0; n_txen = 0;
        for (int c = 0; c < 50 && !(m_active && cyc == m_g + 20); c++) cycle_step();
        rq_byte[3]  = 8'h77;
        rq_valid[3] = 1'b1;
        repeat (30) cycle_step();
        rq_valid[3] = 1'b0;
        repeat (250) cycle_step();
        chk("req3_never_ready", 32'(n_rdy3), 0);
        chk("req3_no_extra_frame", 32'(n_txen), 1);

        // Randomised traffic and baud ticks against the reference model
        do_reset();
        mode      = MODE_RANDOM;
        bd_random = 1'b1;
        repeat (6000) cycle_step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
